cci_mpf_shim_mdata_tag_alloc: RTL and testbench

Upstream companion to the EOP detection shim. Downstream MPF stages track in-flight requests by indexing heaps with the low Mdata bits, so those bits must be temporally unique. This block allocates a unique tag per request from a free list and saves the caller's original Mdata. On each response it restores that Mdata, and it returns the tag to the free list only when the response carries end-of-packet (read EOP flag or packed write response).

---
 rtl/cci_mpf_shim_mdata_tag_alloc_pkg.sv | 29 ++
 rtl/cci_mpf_shim_mdata_tag_alloc_free_list.sv | 114 +++++++++++
 rtl/cci_mpf_shim_mdata_tag_alloc.sv | 97 +++++++++
 tb/tb_cci_mpf_shim_mdata_tag_alloc.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_shim_mdata_tag_alloc_pkg.sv
// rtl/cci_mpf_shim_mdata_tag_alloc_pkg.sv - shared types and constants for the Mdata tag allocator
package cci_mpf_shim_mdata_tag_alloc_pkg;

  // Default configuration of the allocator
  localparam int MPF_MAX_ACTIVE_REQS_DEFAULT = 128;
  localparam int MPF_N_MDATA_BITS_DEFAULT    = 16;

  // Free-tag count at or below which callers must stop issuing.
  // Covers the requests already in flight in the caller's pipeline.
  localparam int MPF_TAG_ALM_FULL_THRESHOLD  = 2;

  // Mdata as carried on the request/response channels
  typedef logic [MPF_N_MDATA_BITS_DEFAULT-1:0] t_mpf_mdata;

  // Tag index for the default number of active requests
  typedef logic [$clog2(MPF_MAX_ACTIVE_REQS_DEFAULT)-1:0] t_tag_idx;

  // Free list life cycle: fill with every tag, then serve pops/pushes
  typedef enum logic [0:0] {
    FL_INIT = 1'b0,
    FL_RUN  = 1'b1
  } t_free_list_state;

  // True when a free count has reached the almost-full threshold
  function automatic logic at_or_below(input logic [31:0] cnt, input logic [31:0] thresh);
    return cnt <= thresh;
  endfunction

endpackage

// File: rtl/cci_mpf_shim_mdata_tag_alloc_free_list.sv
// rtl/cci_mpf_shim_mdata_tag_alloc_free_list.sv - circular free list of tags with init fill, pop/push and count
module cci_mpf_shim_mdata_tag_alloc_free_list
  import cci_mpf_shim_mdata_tag_alloc_pkg::*;
#(
  parameter int N_ENTRIES          = MPF_MAX_ACTIVE_REQS_DEFAULT,
  parameter int ALM_FULL_THRESHOLD = MPF_TAG_ALM_FULL_THRESHOLD,
  localparam int N_IDX             = $clog2(N_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,

  output logic             rdy_o,
  output logic             almfull_o,

  input  logic             pop_i,
  output logic [N_IDX-1:0] pop_idx_o,

  input  logic             push_i,
  input  logic [N_IDX-1:0] push_idx_i,

  output logic [N_IDX:0]   free_cnt_o
);

  localparam logic [N_IDX:0]   FULL_CNT = (N_IDX+1)'(N_ENTRIES);
  localparam logic [N_IDX-1:0] LAST_IDX = N_IDX'(N_ENTRIES - 1);

  t_free_list_state state_q, state_d;

  logic [N_IDX-1:0] ring_q [N_ENTRIES];
  logic [N_IDX-1:0] head_q, head_d;
  logic [N_IDX-1:0] tail_q, tail_d;
  logic [N_IDX:0]   free_cnt_q, free_cnt_d;
  logic             almfull_q;

  logic             wr_en;
  logic [N_IDX-1:0] wr_data;

  // Next state: INIT writes tag == slot index at the tail each cycle;
  // RUN pops at the head and appends released tags at the tail.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    free_cnt_d = free_cnt_q;
    wr_en      = 1'b0;
    wr_data    = push_idx_i;

    case (state_q)
      FL_INIT: begin
        wr_en      = 1'b1;
        wr_data    = tail_q;
        tail_d     = tail_q + 1'b1;
        free_cnt_d = free_cnt_q + 1'b1;
        if (tail_q == LAST_IDX) begin
          state_d = FL_RUN;
        end
      end

      FL_RUN: begin
        wr_en = push_i;
        if (pop_i) begin
          head_d = head_q + 1'b1;
        end
        if (push_i) begin
          tail_d = tail_q + 1'b1;
        end
        if (pop_i && !push_i) begin
          free_cnt_d = free_cnt_q - 1'b1;
        end else if (push_i && !pop_i) begin
          free_cnt_d = free_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State, pointers and count; almfull is derived from next-state count so
  // it reflects this cycle's pops and pushes without extra lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FL_INIT;
      head_q     <= '0;
      tail_q     <= '0;
      free_cnt_q <= '0;
      almfull_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      free_cnt_q <= free_cnt_d;
      almfull_q  <= (state_d != FL_RUN) ||
                    at_or_below(32'(free_cnt_d), 32'(ALM_FULL_THRESHOLD));
    end
  end

  // Ring storage write port
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      ring_q[tail_q] <= wr_data;
    end
  end

  assign rdy_o      = (state_q == FL_RUN);
  assign almfull_o  = almfull_q;
  assign pop_idx_o  = ring_q[head_q];
  assign free_cnt_o = free_cnt_q;

  // Caller protocol: pops only when ready with a free tag, pushes never overfill
  a_pop_legal: assert property (@(posedge clk) disable iff (reset)
    pop_i |-> (state_q == FL_RUN) && (free_cnt_q != '0));

  a_push_legal: assert property (@(posedge clk) disable iff (reset)
    push_i |-> (free_cnt_q != FULL_CNT));

endmodule

// File: rtl/cci_mpf_shim_mdata_tag_alloc.sv
// rtl/cci_mpf_shim_mdata_tag_alloc.sv - unique Mdata tag allocation with original Mdata save/restore
module cci_mpf_shim_mdata_tag_alloc
  import cci_mpf_shim_mdata_tag_alloc_pkg::*;
#(
  parameter int MAX_ACTIVE_REQS    = MPF_MAX_ACTIVE_REQS_DEFAULT,
  parameter int N_MDATA_BITS       = MPF_N_MDATA_BITS_DEFAULT,
  parameter int ALM_FULL_THRESHOLD = MPF_TAG_ALM_FULL_THRESHOLD,
  localparam int N_IDX             = $clog2(MAX_ACTIVE_REQS)
) (
  input  logic                    clk,
  input  logic                    reset,

  output logic                    rdy_o,
  output logic                    req_almfull_o,

  input  logic                    req_en_i,
  input  logic [N_MDATA_BITS-1:0] req_mdata_i,
  output logic [N_IDX-1:0]        req_tag_o,

  input  logic                    rsp_en_i,
  input  logic [N_IDX-1:0]        rsp_tag_i,
  input  logic                    rsp_eop_i,
  output logic [N_MDATA_BITS-1:0] T1_rsp_mdata_o,

  output logic [N_IDX:0]          n_active_o
);

  localparam logic [N_IDX:0] FULL_CNT = (N_IDX+1)'(MAX_ACTIVE_REQS);

  logic [N_IDX:0]          free_cnt;

  logic                    rel_valid_q;
  logic [N_IDX-1:0]        rel_tag_q;

  logic                    wr_valid_q;
  logic [N_IDX-1:0]        wr_idx_q;
  logic [N_MDATA_BITS-1:0] wr_mdata_q;

  logic [N_MDATA_BITS-1:0] mdata_ram [MAX_ACTIVE_REQS];
  logic [N_MDATA_BITS-1:0] rsp_mdata_q;

  cci_mpf_shim_mdata_tag_alloc_free_list #(
    .N_ENTRIES          (MAX_ACTIVE_REQS),
    .ALM_FULL_THRESHOLD (ALM_FULL_THRESHOLD)
  ) u_free_list (
    .clk        (clk),
    .reset      (reset),
    .rdy_o      (rdy_o),
    .almfull_o  (req_almfull_o),
    .pop_i      (req_en_i),
    .pop_idx_o  (req_tag_o),
    .push_i     (rel_valid_q),
    .push_idx_i (rel_tag_q),
    .free_cnt_o (free_cnt)
  );

  // Release stage: only the last flit of a packet returns its tag; reset drops it
  always_ff @(posedge clk) begin
    if (reset) begin
      rel_valid_q <= 1'b0;
    end else begin
      rel_valid_q <= rsp_en_i && rsp_eop_i;
    end
    rel_tag_q <= rsp_tag_i;
  end

  // Capture each allocation so its Mdata write lands on the following edge
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid_q <= 1'b0;
    end else begin
      wr_valid_q <= req_en_i;
    end
    wr_idx_q   <= req_tag_o;
    wr_mdata_q <= req_mdata_i;
  end

  // Saved Mdata write port
  always_ff @(posedge clk) begin
    if (wr_valid_q) begin
      mdata_ram[wr_idx_q] <= wr_mdata_q;
    end
  end

  // Saved Mdata read port: restored value for every response flit, one cycle later
  always_ff @(posedge clk) begin
    if (rsp_en_i) begin
      rsp_mdata_q <= mdata_ram[rsp_tag_i];
    end
  end

  assign T1_rsp_mdata_o = rsp_mdata_q;

  // Free count climbs during INIT, so report no activity until the list is ready
  assign n_active_o = rdy_o ? (FULL_CNT - free_cnt) : '0;

endmodule

// File: tb/tb_cci_mpf_shim_mdata_tag_alloc.sv
// tb/tb_cci_mpf_shim_mdata_tag_alloc.sv - self-checking bench for the Mdata tag allocator
module tb_cci_mpf_shim_mdata_tag_alloc;

  localparam int N  = 128;
  localparam int NB = 16;
  localparam int TH = 2;
  localparam int NI = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rdy;
  logic          almfull;
  logic          req_en = 1'b0;
  logic [NB-1:0] req_mdata = '0;
  logic [NI-1:0] req_tag;
  logic          rsp_en = 1'b0;
  logic [NI-1:0] rsp_tag = '0;
  logic          rsp_eop = 1'b0;
  logic [NB-1:0] t1_mdata;
  logic [NI:0]   n_active;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO of poppable tags, outstanding set, saved Mdata
  int            free_q[$];
  bit            outstanding [N];
  bit            rel_pend [N];
  logic [NB-1:0] saved [N];
  int            alloc_cyc [N];

  always #5 clk = ~clk;

  cci_mpf_shim_mdata_tag_alloc #(
    .MAX_ACTIVE_REQS    (N),
    .N_MDATA_BITS       (NB),
    .ALM_FULL_THRESHOLD (TH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rdy_o          (rdy),
    .req_almfull_o  (almfull),
    .req_en_i       (req_en),
    .req_mdata_i    (req_mdata),
    .req_tag_o      (req_tag),
    .rsp_en_i       (rsp_en),
    .rsp_tag_i      (rsp_tag),
    .rsp_eop_i      (rsp_eop),
    .T1_rsp_mdata_o (t1_mdata),
    .n_active_o     (n_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (rdy !== 1'b1 && cyc < 300);
  endtask

  task automatic model_fill();
    free_q.delete();
    for (int t = 0; t < N; t++) begin
      free_q.push_back(t);
      outstanding[t] = 1'b0;
      rel_pend[t]    = 1'b0;
      alloc_cyc[t]   = -10;
    end
  endtask

  task automatic model_pop(input logic [NB-1:0] md, input int cyc);
    int t;
    t = free_q.pop_front();
    outstanding[t] = 1'b1;
    saved[t]       = md;
    alloc_cyc[t]   = cyc;
  endtask

  task automatic model_release(input int t);
    free_q.push_back(t);
    outstanding[t] = 1'b0;
    rel_pend[t]    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int            cyc;
    int            t;
    int            start;
    bit            do_r, do_s, s_eop, prev_rsp, st_v;
    int            s_tag, prev_tag, st_tag;
    logic [NB-1:0] md;

    // ---- reset state
    reset = 1'b1;
    tick(); tick(); tick();
    chk("reset_rdy", 32'(rdy), 32'd0);
    chk("reset_almfull", 32'(almfull), 32'd1);
    chk("reset_n_active", 32'(n_active), 32'd0);

    // ---- init fill latency
    reset = 1'b0;
    wait_rdy(cyc);
    chk("init_rdy_latency", 32'(cyc), 32'd128);
    chk("init_first_tag", 32'(req_tag), 32'd0);
    chk("init_n_active", 32'(n_active), 32'd0);
    chk("init_almfull", 32'(almfull), 32'd0);
    model_fill();

    // ---- 126 back-to-back allocations; tag 5 carries 0xBEEF
    for (int i = 0; i < 126; i++) begin
      chk("b2b_tag", 32'(req_tag), 32'(i));
      md = (i == 5) ? 16'hBEEF : NB'($urandom);
      req_en = 1'b1;
      req_mdata = md;
      tick();
      model_pop(md, -5);
      chk("b2b_almfull", 32'(almfull), 32'((N - (i + 1)) <= TH));
    end
    req_en = 1'b0;
    chk("b2b_n_active", 32'(n_active), 32'd126);
    chk("b2b_almfull_final", 32'(almfull), 32'd1);

    // ---- tag 5: non-EOP flit restores Mdata but keeps the tag
    rsp_en = 1'b1; rsp_tag = NI'(5); rsp_eop = 1'b0;
    tick();
    rsp_en = 1'b0;
    chk("rsp5_noeop_mdata", 32'(t1_mdata), 32'hBEEF);
    tick(); tick();
    chk("rsp5_noeop_n_active", 32'(n_active), 32'd126);

    // ---- tag 5: EOP flit releases the tag
    rsp_en = 1'b1; rsp_tag = NI'(5); rsp_eop = 1'b1;
    tick();
    rsp_en = 1'b0;
    chk("rsp5_eop_mdata", 32'(t1_mdata), 32'hBEEF);
    tick();
    chk("rsp5_eop_n_active", 32'(n_active), 32'd125);
    model_release(5);

    // ---- drain: remaining free tags come out in FIFO order (126, 127, 5)
    for (int k = 0; k < 3; k++) begin
      chk("drain_tag", 32'(req_tag), 32'(free_q[0]));
      md = NB'($urandom);
      req_en = 1'b1;
      req_mdata = md;
      tick();
      model_pop(md, -5);
    end
    req_en = 1'b0;
    chk("drain_n_active", 32'(n_active), 32'd128);
    chk("drain_almfull", 32'(almfull), 32'd1);

    // ---- release tag 7 into an empty list; poppable two cycles later
    rsp_en = 1'b1; rsp_tag = NI'(7); rsp_eop = 1'b1;
    tick();
    rsp_en = 1'b0;
    chk("rel7_mdata", 32'(t1_mdata), 32'(saved[7]));
    tick();
    model_release(7);
    chk("rel7_tag", 32'(req_tag), 32'd7);
    chk("rel7_n_active", 32'(n_active), 32'd127);

    // ---- simultaneous pop (tag 7) and push (tag 9)
    rsp_en = 1'b1; rsp_tag = NI'(9); rsp_eop = 1'b1;
    tick();
    rsp_en = 1'b0;
    chk("sim_rsp9_mdata", 32'(t1_mdata), 32'(saved[9]));
    md = NB'($urandom);
    req_en = 1'b1;
    req_mdata = md;
    tick();
    req_en = 1'b0;
    model_pop(md, -5);
    model_release(9);
    chk("sim_n_active", 32'(n_active), 32'd127);
    chk("sim_tag", 32'(req_tag), 32'd9);
    tick(); tick();

    // ---- randomized allocate/release against the model
    prev_rsp = 1'b0; prev_tag = 0; st_v = 1'b0; st_tag = 0;
    for (int i = 0; i < 1000; i++) begin
      chk("rnd_n_active", 32'(n_active), 32'(N - free_q.size()));
      chk("rnd_almfull", 32'(almfull), 32'(free_q.size() <= TH));
      if (free_q.size() > 0) begin
        chk("rnd_tag", 32'(req_tag), 32'(free_q[0]));
      end
      if (prev_rsp) begin
        chk("rnd_mdata", 32'(t1_mdata), 32'(saved[prev_tag]));
      end

      do_r = (free_q.size() > 0) && ($urandom_range(0, 1) == 1);
      if (do_r) begin
        chk("rnd_tag_not_outstanding", 32'(outstanding[int'(req_tag)]), 32'd0);
      end
      do_s = 1'b0;
      s_tag = 0;
      if ($urandom_range(0, 9) < 6) begin
        start = $urandom_range(0, N - 1);
        for (int k = 0; k < N; k++) begin
          t = (start + k) % N;
          if (outstanding[t] && !rel_pend[t] && (i - alloc_cyc[t] >= 2)) begin
            do_s = 1'b1;
            s_tag = t;
            break;
          end
        end
      end
      s_eop = ($urandom_range(0, 3) != 0);
      md = NB'($urandom);

      req_en = do_r; req_mdata = md;
      rsp_en = do_s; rsp_tag = NI'(s_tag); rsp_eop = s_eop;
      tick();

      if (do_r) model_pop(md, i);
      if (st_v) model_release(st_tag);
      st_v = do_s && s_eop;
      st_tag = s_tag;
      if (st_v) rel_pend[s_tag] = 1'b1;
      prev_rsp = do_s;
      prev_tag = s_tag;
    end
    req_en = 1'b0;
    rsp_en = 1'b0;
    if (prev_rsp) begin
      chk("rnd_mdata_last", 32'(t1_mdata), 32'(saved[prev_tag]));
    end
    tick();
    if (st_v) model_release(st_tag);
    tick();
    chk("rnd_final_n_active", 32'(n_active), 32'(N - free_q.size()));

    // ---- reset with 40 tags active and a release pending in the register stage
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_rdy(cyc);
    chk("reinit1_latency", 32'(cyc), 32'd128);
    for (int k = 0; k < 40; k++) begin
      chk("pre_reset_tag", 32'(req_tag), 32'(k));
      req_en = 1'b1;
      req_mdata = NB'($urandom);
      tick();
    end
    req_en = 1'b0;
    chk("pre_reset_n_active", 32'(n_active), 32'd40);
    rsp_en = 1'b1; rsp_tag = NI'(3); rsp_eop = 1'b1;
    tick();
    rsp_en = 1'b0;
    reset = 1'b1;
    tick();
    chk("midreset_rdy", 32'(rdy), 32'd0);
    chk("midreset_almfull", 32'(almfull), 32'd1);
    chk("midreset_n_active", 32'(n_active), 32'd0);
    reset = 1'b0;
    wait_rdy(cyc);
    chk("reinit2_latency", 32'(cyc), 32'd128);
    chk("reinit2_n_active", 32'(n_active), 32'd0);
    for (int k = 0; k < N; k++) begin
      chk("reinit2_tag", 32'(req_tag), 32'(k));
      req_en = 1'b1;
      req_mdata = NB'($urandom);
      tick();
    end
    req_en = 1'b0;
    chk("reinit2_full_n_active", 32'(n_active), 32'd128);
    chk("reinit2_full_almfull", 32'(almfull), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
